// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer:
// state encoding, configuration defaults and the datapath control bundle.
package mult_ctrl_pkg;

   localparam int N_BITS_DEF   = 16;
   localparam int WDOG_MAX_DEF = 18;

   typedef enum logic [2:0] {
      ST_CLR  = 3'd0,
      ST_IDLE = 3'd1,
      ST_LOAD = 3'd2,
      ST_CALC = 3'd3,
      ST_FIN  = 3'd4
   } state_e;

   typedef struct packed {
      logic busy_sel;
      logic busy_en;
      logic prod_sel;
      logic prod_en;
      logic i_sel;
      logic i_en;
      logic mask_sel;
      logic mask_en;
      logic m_sel;
      logic m_en;
      logic n_en;
   } ctrl_t;

endpackage

// File: rtl/mult_controller.sv
// Sequencer for the 16-bit shift-add multiplier datapath: start/done host
// handshake, one multiplier bit per CALC cycle, abort and iteration watchdog.
module mult_controller
   import mult_ctrl_pkg::*;
#(
   parameter int N_BITS   = N_BITS_DEF,
   parameter int WDOG_MAX = WDOG_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   output logic ready,
   output logic done,
   output logic err,
   input  logic i_zero,
   input  logic mask_n_zero,
   output logic busy_sel,
   output logic busy_en,
   output logic prod_sel,
   output logic prod_en,
   output logic i_sel,
   output logic i_en,
   output logic mask_sel,
   output logic mask_en,
   output logic m_sel,
   output logic m_en,
   output logic n_en
);

   // A clean run spends N_BITS+1 cycles in CALC; a shorter limit would kill every operation.
   localparam int WDOG_LIMIT = (WDOG_MAX >= N_BITS + 2) ? WDOG_MAX : N_BITS + 2;
   localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

   state_e              state_q, state_d;
   logic                err_q, err_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic                wdog_expire;
   ctrl_t               ctrl_c, ctrl_g;
   logic                ready_c, done_c, err_c;

   assign wdog_expire = (wdog_q == WDOG_W'(WDOG_LIMIT - 1));

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      wdog_d  = wdog_q;
      ctrl_c  = '0;
      ready_c = 1'b0;
      done_c  = 1'b0;
      err_c   = 1'b0;
      unique case (state_q)
         ST_CLR: begin
            ctrl_c.busy_en = 1'b1;
            state_d        = ST_IDLE;
         end
         ST_IDLE: begin
            ready_c = 1'b1;
            if (start) begin
               state_d = ST_LOAD;
               wdog_d  = '0;
            end
         end
         ST_LOAD: begin
            ctrl_c.busy_en  = 1'b1;
            ctrl_c.busy_sel = 1'b1;
            ctrl_c.prod_en  = 1'b1;
            ctrl_c.i_en     = 1'b1;
            ctrl_c.mask_en  = 1'b1;
            ctrl_c.m_en     = 1'b1;
            ctrl_c.n_en     = 1'b1;
            if (abort) begin
               state_d = ST_FIN;
               err_d   = 1'b1;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            wdog_d = wdog_q + 1'b1;
            if (abort || wdog_expire) begin
               state_d = ST_FIN;
               err_d   = 1'b1;
            end else if (i_zero) begin
               state_d = ST_FIN;
            end else begin
               ctrl_c.i_en     = 1'b1;
               ctrl_c.i_sel    = 1'b1;
               ctrl_c.mask_en  = 1'b1;
               ctrl_c.mask_sel = 1'b1;
               ctrl_c.m_en     = 1'b1;
               ctrl_c.m_sel    = 1'b1;
               ctrl_c.prod_sel = 1'b1;
               ctrl_c.prod_en  = ~mask_n_zero;
            end
         end
         ST_FIN: begin
            done_c         = 1'b1;
            err_c          = err_q;
            ctrl_c.busy_en = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_CLR;
      endcase
   end

   // Outputs are forced low while reset is held, even though the state already reads CLR.
   always_comb begin
      ctrl_g = rst_n ? ctrl_c : '0;
      ready  = rst_n & ready_c;
      done   = rst_n & done_c;
      err    = rst_n & err_c;
   end

   assign {busy_sel, busy_en, prod_sel, prod_en, i_sel, i_en,
           mask_sel, mask_en, m_sel, m_en, n_en} = ctrl_g;

   // NOTE: registered state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLR;
         err_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: a behavioural shift-add datapath closes the loop,
// table-driven operations plus hand-written reset, back-to-back and reset-abort sequences.
module tb_mult_controller;
   import mult_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic ready, done, err, i_zero, mask_n_zero;
   logic busy_sel, busy_en, prod_sel, prod_en, i_sel, i_en;
   logic mask_sel, mask_en, m_sel, m_en, n_en;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_controller dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .ready(ready), .done(done), .err(err),
      .i_zero(i_zero), .mask_n_zero(mask_n_zero),
      .busy_sel(busy_sel), .busy_en(busy_en), .prod_sel(prod_sel), .prod_en(prod_en),
      .i_sel(i_sel), .i_en(i_en), .mask_sel(mask_sel), .mask_en(mask_en),
      .m_sel(m_sel), .m_en(m_en), .n_en(n_en)
   );

   // Behavioural datapath; busy starts as X to show CLR clears it.
   logic        busy;
   logic [15:0] prod, m_r, n_r, mask_r, m_in, n_in;
   logic [4:0]  i_r;
   logic        stuck = 1'b0;

   assign i_zero      = !stuck && (i_r == 5'd0);
   assign mask_n_zero = ((mask_r & n_r) == 16'h0);

   always @(posedge clk) begin
      if (busy_en) busy   <= busy_sel;
      if (prod_en) prod   <= prod_sel ? prod + m_r : 16'h0;
      if (i_en)    i_r    <= i_sel ? i_r - 5'd1 : 5'd16;
      if (mask_en) mask_r <= mask_sel ? mask_r << 1 : 16'h1;
      if (m_en)    m_r    <= m_sel ? m_r << 1 : m_in;
      if (n_en)    n_r    <= n_in;
   end

   logic [10:0] ctl;
   assign ctl = {busy_sel, busy_en, prod_sel, prod_en, i_sel, i_en,
                 mask_sel, mask_en, m_sel, m_en, n_en};

   localparam logic [10:0] CTL_BUSY_CLR = 11'b010_0000_0000;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(ready), 32'd1);
   endtask

   typedef struct {
      logic [15:0] m;
      logic [15:0] n;
      int          abort_k;
      bit          start_abort;
      bit          stuck;
      int          lat;
      bit          err;
      logic [15:0] prod;
      bit          chk_prod;
      int          adds;
   } vec_t;

   vec_t vecs[8];

   task automatic run_op(input vec_t v);
      int lat = -1;
      int adds = 0;
      wait_ready();
      m_in  = v.m;
      n_in  = v.n;
      stuck = v.stuck;
      start = 1'b1;
      abort = v.start_abort;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            abort = 1'b0;
            check("load_n_en", 32'(n_en), 32'd1);
         end
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         if (k == 2) check("busy_calc", 32'(busy), 32'd1);
         if (k >= 2 && prod_en === 1'b1) adds++;
         if (k == v.abort_k) begin
            abort = 1'b1;
            #1;
            check("abort_ctl", 32'(ctl), 32'd0);
         end else begin
            abort = 1'b0;
         end
      end
      abort = 1'b0;
      check("latency", lat, v.lat);
      check("err", 32'(err), 32'(v.err));
      check("fin_ctl", 32'(ctl), 32'(CTL_BUSY_CLR));
      if (v.chk_prod) check("prod", 32'(prod), 32'(v.prod));
      if (v.adds >= 0) check("adds", adds, v.adds);
      stuck = 1'b0;
      @(negedge clk);
      check("ready_after", 32'(ready), 32'd1);
      check("idle_ctl", 32'(ctl), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int d1 = -1;
      int d2 = -1;
      int rdy = 0;

      vecs[0] = '{16'h0003, 16'h0005, 0, 1'b0, 1'b0, 19, 1'b0, 16'h000F, 1'b1, 2};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b0, 19, 1'b0, 16'h0001, 1'b1, 16};
      vecs[2] = '{16'h1234, 16'h0000, 0, 1'b0, 1'b0, 19, 1'b0, 16'h0000, 1'b1, 0};
      vecs[3] = '{16'h00FF, 16'h0101, 0, 1'b0, 1'b0, 19, 1'b0, 16'hFFFF, 1'b1, 2};
      vecs[4] = '{16'h8000, 16'h0003, 0, 1'b0, 1'b0, 19, 1'b0, 16'h8000, 1'b1, 2};
      vecs[5] = '{16'h0007, 16'h0006, 0, 1'b1, 1'b0, 19, 1'b0, 16'h002A, 1'b1, 2};
      vecs[6] = '{16'h0003, 16'h0005, 6, 1'b0, 1'b0, 7,  1'b1, 16'h0000, 1'b0, -1};
      vecs[7] = '{16'h0003, 16'h0005, 0, 1'b0, 1'b1, 20, 1'b1, 16'h0000, 1'b0, -1};

      // Reset held: everything quiet, then exactly one CLR cycle before ready.
      @(negedge clk);
      @(negedge clk);
      check("rst_ctl", 32'(ctl), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      #1;
      check("clr_ctl", 32'(ctl), 32'(CTL_BUSY_CLR));
      check("clr_ready", 32'(ready), 32'd0);
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      foreach (vecs[i]) run_op(vecs[i]);

      // start held high: back-to-back runs with exactly one IDLE cycle in between.
      wait_ready();
      m_in  = 16'h0003;
      n_in  = 16'h0005;
      start = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (d1 < 0) d1 = k;
            else begin
               d2 = k;
               break;
            end
         end else if (d1 >= 0 && ready === 1'b1) begin
            rdy++;
         end
      end
      check("b2b_spacing", d2 - d1, 20);
      check("b2b_idle_cycles", rdy, 1);
      check("b2b_prod", 32'(prod), 32'h0000000F);

      // Third run starts; reset it mid-CALC and confirm no done pulse follows.
      repeat (4) @(negedge clk);
      check("pre_rst_calc", 32'(i_en), 32'd1);
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("midrst_ctl", 32'(ctl), 32'd0);
      check("midrst_ready", 32'(ready), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_clr", 32'(ctl), 32'(CTL_BUSY_CLR));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("midrst_no_done", 32'(done), 32'd0);
      end
      check("midrst_ready_after", 32'(ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_controller.md
Name: mult_controller

Overview:
- FSM sequencer for the 16-bit shift-add multiplier datapath.
- Drives every datapath enable/select, consumes its status flags (i_zero, mask_n_zero), and offers a start/done handshake to the host.
- Adds an abort input and an iteration watchdog.
- Sits between the host/register interface and the multiplier datapath, clocked on the same clk.

Parameters:
- N_BITS, 16, operand width and iteration count; must equal the datapath's i reload value.
- WDOG_MAX, 18, CALC cycles allowed before the watchdog forces an error termination.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  host request; sampled only in IDLE
- abort  in  1  host cancel; honoured in LOAD and CALC
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse; datapath prod is valid while done=1
- err  out  1  one-cycle pulse coincident with done on abort or watchdog
- i_zero  in  1  datapath status: iteration counter is 0
- mask_n_zero  in  1  datapath status: current multiplier bit is 0
- busy_sel, busy_en, prod_sel, prod_en, i_sel, i_en, mask_sel, mask_en, m_sel, m_en, n_en  out  1 each  datapath controls

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- States: CLR, IDLE, LOAD, CALC, FIN. Registered state; outputs are a Moore decode of state, except prod_en in CALC.
- Reset: state=CLR. All datapath controls=0, ready=0, done=0, err=0 while rst_n=0. Watchdog count=0.
- CLR (one cycle):
  - busy_en=1, busy_sel=0, so the unreset datapath busy flag is cleared.
  - Next state: IDLE.
- IDLE:
  - ready=1; all controls 0.
  - start=1 -> LOAD. abort is ignored here.
- LOAD:
  - busy_en=1, busy_sel=1.
  - prod_en/i_en/mask_en/m_en=1, all *_sel=0; n_en=1.
  - Next state: CALC. If abort=1, go to FIN with err flagged; the loads still occur.
- CALC, when i_zero=0:
  - i_en/mask_en/m_en=1 with i_sel/mask_sel/m_sel=1.
  - prod_en = ~mask_n_zero, prod_sel=1.
  - One multiplier bit per cycle. prod uses pre-shift m (same-edge semantics).
- CALC exit:
  - i_zero=1: all controls 0, next state FIN.
  - abort=1: all controls 0, next state FIN with err flagged. abort has priority over iteration.
- Watchdog:
  - Counts CALC cycles; cleared on entry to LOAD.
  - If the count reaches WDOG_MAX while still in CALC, go to FIN with err flagged.
- FIN (one cycle):
  - done=1; err=1 if flagged.
  - busy_en=1, busy_sel=0.
  - Next state: IDLE. The err flag clears in IDLE.
- Latency (edge 1 = first edge sampling start=1 in IDLE):
  - LOAD after edge 1.
  - CALC after edge 2, i=16.
  - 16 iterations on edges 3-18.
  - i_zero seen and FIN entered on edge 19; done high during the cycle after edge 19.
  - IDLE/ready after edge 20.
  - Back-to-back start is accepted on the ready cycle.
- Boundary conditions:
  - start while not IDLE: ignored, no queuing.
  - start held high through FIN: re-accepted in IDLE on the next cycle.
  - Simultaneous start and abort in IDLE: start wins.
  - Reset mid-operation: immediate return to CLR; datapath registers are left stale; no done pulse.
  - Datapath busy mirrors controller activity: 1 from the edge leaving LOAD through the edge leaving FIN.

Decomposition:
- Package mult_ctrl_pkg:
  - state encoding enum (CLR, IDLE, LOAD, CALC, FIN)
  - N_BITS default and WDOG_MAX default constants
  - a control-bundle struct grouping the eleven datapath controls
- No sub-module required. The watchdog counter may be split into mult_wdog (count, clear, expire) if reused elsewhere.
- Top-level integration instantiates mult_controller beside the datapath.

Test Plan:
- Reset release:
  - one CLR cycle with busy_en=1, busy_sel=0, then ready=1.
  - datapath busy reads 0 even if the datapath initialised busy to X.
- m_in=3, n_in=5, start pulse -> done exactly 19 cycles after start sampled; prod=15; err=0; ready one cycle later.
- Operand edge cases:
  - m_in=16'hFFFF, n_in=16'hFFFF -> prod=16'h0001 (truncated).
  - n_in=0 -> prod_en never asserted in CALC; prod=0.
- abort asserted on the 5th CALC cycle -> FIN next cycle, done=1 with err=1, then IDLE; no further datapath enables.
- Watchdog: force i_zero stuck at 0 -> err+done after WDOG_MAX=18 CALC cycles.
- start asserted in every cycle -> operations run back-to-back with exactly one IDLE cycle between FIN and LOAD; a mid-CALC rst_n low returns to CLR with no done pulse.
